mac_sequencer: RTL
==================

// Module: mac_sequencer
// PURPOSE
//  Job-level controller for the 8x8 Dadda MAC datapath (processing_block).
//  - Accepts a job (start + len), streams len operand pairs in over valid/ready.
//  - Drives the datapath with the partial-product array of each pair and the running accumulator.
//  - Captures the 17-bit MAC sum into a saturating 16-bit accumulator.
//  - Returns the final sum over valid/ready. Sits between the operand source and the top-level MAC datapath.
// PARAMETERS
//  CNT_W   8    width of len and the internal pair counters (max job = 2^CNT_W-1 pairs)
// PORTS
//  clk        in   1        clock, all state on rising edge
//  rst_n      in   1        asynchronous active-low reset
//  start      in   1        job request, sampled only in IDLE
//  len        in   CNT_W    number of operand pairs in the job, sampled with start
//  busy       out  1        high in RUN and DONE
//  in_valid   in   1        operand pair valid
//  in_ready   out  1        sequencer can take a pair
//  in_a       in   8        multiplicand
//  in_b       in   8        multiplier
//  pp_o       out  [7:0][7:0]  partial products to datapath, pp_o[i][j] = s_b[i] & s_a[j]
//  m_acc_o    out  16       accumulator to datapath M input (= acc register)
//  mac_i      in   17       datapath MAC result (pp sum + M), combinational from pp_o/m_acc_o
//  out_valid  out  1        result valid, held until accepted
//  out_ready  in   1        result consumer ready
//  out_acc    out  16       final accumulator
//  out_ovf    out  1        sticky overflow flag for the job
// BEHAVIOUR
//  Reset: state=IDLE; acc, counters, stage regs, out_ovf = 0; busy, in_ready, out_valid = 0.
//  States:
//   - IDLE -> RUN on start: acc, ovf cleared; len latched; accepted-pair count (acc_cnt) = 0.
//   - IDLE -> DONE on start with len=0: out_valid asserted next cycle, out_acc=0.
//   - RUN -> DONE at the edge where the last pair's stage update is committed.
//   - DONE -> IDLE on out_valid & out_ready.
//   - start outside IDLE is ignored (no queueing).
//  Operand stage (one register):
//   - in_ready = (state==RUN) && (acc_cnt < len).
//   - Handshake at edge k: s_a<=in_a, s_b<=in_b, s_vld<=1, acc_cnt++.
//   - Otherwise s_vld<=0.
//   - pp_o is driven from s_a/s_b (registered source); pp_o = 0 when !s_vld.
//  Accumulate:
//   - At edge k+1, if s_vld: acc <= (mac_i[16] | ovf) ? 16'hFFFF : mac_i[15:0].
//   - ovf <= ovf | mac_i[16]. Once saturated, acc stays 16'hFFFF for the rest of the job.
//  Latency: out_valid rises 2 edges after the last pair's handshake edge.
//   - Throughput is 1 pair/cycle with in_valid held high.
//   - in_valid gaps only stall; order is preserved.
//  Outputs:
//   - out_acc = acc; out_ovf = ovf.
//   - Both are stable while out_valid=1 and out_ready=0.
//   - acc and ovf are cleared only at the next accepted start.
//  Reset mid-operation: immediate return to the reset state. The in-flight pair and partial sum are discarded.
//  Width rule: mac_i is unsigned 17-bit. Products are unsigned; no signed modes.
// STRUCTURE
//  - Package mac_seq_pkg: state_t enum {IDLE, RUN, DONE}, OP_W=8, ACC_W=16, ACC_SAT=16'hFFFF.
//  - Sub-module pp_gen (8x8 AND array, s_a/s_b/s_vld -> pp_o). Counter/FSM/accumulator stay in mac_sequencer.
//  - processing_block is instantiated at top level, not here. The bench supplies a behavioural model (mac_i = a*b + M).
// TESTING
//  1 Reset: hold rst_n=0 mid-clock -> busy=0, in_ready=0, out_valid=0, out_acc=0, out_ovf=0 asynchronously.
//  2 len=3, pairs (3,5),(7,9),(255,1) back-to-back -> out_acc=16'h014D (333), out_ovf=0, out_valid 2 edges after 3rd handshake.
//  3 len=0 start -> out_valid next cycle, out_acc=0; in_ready never asserts.
//  4 len=2, pairs (255,255),(255,255) -> first acc=16'hFE01, then out_acc=16'hFFFF, out_ovf=1.
//  5 len=4, in_valid toggling and out_ready low 5 cycles -> sum correct; out_acc/out_valid stable until out_ready; start during busy ignored.
//  6 Reset asserted after 2 of 4 pairs -> all outputs to reset values; new job len=1 (2,3) -> out_acc=6.

Source files
------------

// File: rtl/mac_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mac_seq_pkg                                                          |
// | Shared widths, saturation constant and FSM states for mac_sequencer. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mac_seq_pkg;
    localparam int OP_W  = 8;
    localparam int ACC_W = 16;
    localparam int MAC_W = ACC_W + 1;
    localparam logic [ACC_W-1:0] ACC_SAT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage
`default_nettype wire

// File: rtl/mac_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mac_sequencer_if                                                     |
// | Job, operand, datapath and result signals of the MAC sequencer.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface mac_sequencer_if #(
    parameter int CNT_W = 8
);
    import mac_seq_pkg::*;

    logic                       start;
    logic [CNT_W-1:0]           len;
    logic                       busy;
    logic                       in_valid;
    logic                       in_ready;
    logic [OP_W-1:0]            in_a;
    logic [OP_W-1:0]            in_b;
    logic [OP_W-1:0][OP_W-1:0]  pp_o;
    logic [ACC_W-1:0]           m_acc_o;
    logic [MAC_W-1:0]           mac_i;
    logic                       out_valid;
    logic                       out_ready;
    logic [ACC_W-1:0]           out_acc;
    logic                       out_ovf;

    modport master (
        output start, len, in_valid, in_a, in_b, out_ready, mac_i,
        input  busy, in_ready, pp_o, m_acc_o, out_valid, out_acc, out_ovf
    );

    modport slave (
        input  start, len, in_valid, in_a, in_b, out_ready, mac_i,
        output busy, in_ready, pp_o, m_acc_o, out_valid, out_acc, out_ovf
    );
endinterface
`default_nettype wire

// File: rtl/pp_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pp_gen                                                               |
// | 8x8 AND array: o_pp[i][j] = b[i] & a[j], zeroed when stage is empty. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pp_gen
    import mac_seq_pkg::*;
(
    input  logic [OP_W-1:0]           i_a,
    input  logic [OP_W-1:0]           i_b,
    input  logic                      i_vld,
    output logic [OP_W-1:0][OP_W-1:0] o_pp
);
    for (genvar i = 0; i < OP_W; i++) begin : g_row
        for (genvar j = 0; j < OP_W; j++) begin : g_col
            assign o_pp[i][j] = i_vld & i_b[i] & i_a[j];
        end
    end
endmodule
`default_nettype wire

// File: rtl/mac_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mac_sequencer                                                        |
// | Job controller: streams operand pairs, saturating 16-bit accumulate. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mac_sequencer
    import mac_seq_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    mac_sequencer_if.slave bus
);
    state_t                    r_state;
    logic [CNT_W-1:0]          r_len;
    logic [CNT_W-1:0]          r_acc_cnt;
    logic [OP_W-1:0]           r_s_a;
    logic [OP_W-1:0]           r_s_b;
    logic                      r_s_vld;
    logic [ACC_W-1:0]          r_acc;
    logic                      r_ovf;
    logic                      r_out_valid;
    logic                      w_in_ready;
    logic                      w_in_hs;
    logic                      w_last_commit;
    logic [OP_W-1:0][OP_W-1:0] w_pp;

    assign w_in_ready    = (r_state == RUN) && (r_acc_cnt < r_len);
    assign w_in_hs       = w_in_ready && bus.in_valid;
    // Stage holds the final pair once every pair of the job has been accepted
    assign w_last_commit = r_s_vld && (r_acc_cnt == r_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_acc_cnt   <= '0;
            r_s_a       <= '0;
            r_s_b       <= '0;
            r_s_vld     <= 1'b0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_s_vld <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_out_valid <= 1'b0;
                    if (bus.start) begin
                        r_acc     <= '0;
                        r_ovf     <= 1'b0;
                        r_len     <= bus.len;
                        r_acc_cnt <= '0;
                        if (bus.len == '0) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (w_in_hs) begin
                        r_s_a     <= bus.in_a;
                        r_s_b     <= bus.in_b;
                        r_s_vld   <= 1'b1;
                        r_acc_cnt <= r_acc_cnt + CNT_W'(1);
                    end
                    if (r_s_vld) begin
                        r_acc <= (bus.mac_i[ACC_W] | r_ovf) ? ACC_SAT : bus.mac_i[ACC_W-1:0];
                        r_ovf <= r_ovf | bus.mac_i[ACC_W];
                    end
                    if (w_last_commit) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (r_out_valid && bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end else begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    pp_gen u_pp_gen (
        .i_a   (r_s_a),
        .i_b   (r_s_b),
        .i_vld (r_s_vld),
        .o_pp  (w_pp)
    );

    assign bus.pp_o      = w_pp;
    assign bus.m_acc_o   = r_acc;
    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = (r_state != IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_acc   = r_acc;
    assign bus.out_ovf   = r_ovf;
endmodule
`default_nettype wire
